// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared state encoding, default sizes and index-width helper for ddram_arb.
package ddram_arb_pkg;
    typedef enum logic {IDLE, WAIT} state_e;
    localparam int NCH_DEF = 3;
    localparam int AW_DEF  = 27;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/ddram_arb_rr.sv
// ddram_arb_rr: combinational round-robin picker; searches from last_i+1 with explicit modulo-NCH wrap.
module ddram_arb_rr #(
    parameter int NCH = 3,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] pending_i,
    input  logic [IW-1:0]  last_i,
    output logic [IW-1:0]  winner_o,
    output logic           valid_o
);
    logic [IW-1:0] idx;
    // Walk offsets from farthest to nearest so the closest pending channel after last_i wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = IW'((int'(last_i) + k) % NCH);
            if (pending_i[idx]) begin
                winner_o = idx;
                valid_o  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ddram_arb.sv
// ddram_arb: toggle-handshake arbiter sharing one 16-bit DDRAM client port among NCH requesters.
// Optional DDRAM_ARB_PRIO0_EN gives channel 0 absolute priority; round-robin then covers 1..NCH-1.
module ddram_arb
    import ddram_arb_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF
) (
    input  logic              DDRAM_CLK,
    input  logic              reset_n,
    input  logic [NCH*AW-1:0] ch_addr,
    input  logic [NCH*16-1:0] ch_din,
    input  logic [NCH*2-1:0]  ch_be,
    input  logic [NCH-1:0]    ch_we,
    input  logic [NCH-1:0]    ch_req,
    output logic [NCH-1:0]    ch_ack,
    output logic [NCH*16-1:0] ch_dout,
    output logic [NCH-1:0]    grant,
    output logic [AW-1:0]     m_addr,
    output logic [15:0]       m_din,
    output logic [1:0]        m_be,
    output logic              m_we,
    output logic              m_req,
    input  logic              m_ack,
    input  logic [15:0]       m_dout
);
    localparam int IW = clog2_min1(NCH);
`ifdef DDRAM_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [IW-1:0]     last_q, last_d, win_q, win_d;
    logic [NCH-1:0]    ack_q, ack_d, grant_q, grant_d;
    logic [NCH*16-1:0] dout_q, dout_d;
    logic [AW-1:0]     m_addr_q, m_addr_d;
    logic [15:0]       m_din_q, m_din_d;
    logic [1:0]        m_be_q, m_be_d;
    logic              m_we_q, m_we_d, m_req_q, m_req_d;
    logic [NCH-1:0]    pending, rr_pend;
    logic [IW-1:0]     rr_win, pick;
    logic              rr_v, pick_v;

    assign pending = ch_req ^ ack_q;
    // With priority enabled channel 0 bypasses the picker and never moves the round-robin pointer.
    assign rr_pend = PRIO0 ? (pending & ~NCH'(1)) : pending;
    assign pick    = (PRIO0 && pending[0]) ? '0 : rr_win;
    assign pick_v  = PRIO0 ? |pending : rr_v;

    ddram_arb_rr #(.NCH(NCH), .IW(IW)) u_rr (
        .pending_i (rr_pend),
        .last_i    (last_q),
        .winner_o  (rr_win),
        .valid_o   (rr_v)
    );

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        ack_d    = ack_q;
        dout_d   = dout_q;
        grant_d  = grant_q;
        m_addr_d = m_addr_q;
        m_din_d  = m_din_q;
        m_be_d   = m_be_q;
        m_we_d   = m_we_q;
        m_req_d  = m_req_q;
        if (state_q == IDLE && pick_v) begin
            win_d    = pick;
            grant_d  = NCH'(1) << pick;
            m_addr_d = ch_addr[pick*AW +: AW];
            m_din_d  = ch_din[pick*16 +: 16];
            m_be_d   = ch_be[pick*2 +: 2];
            m_we_d   = ch_we[pick];
            m_req_d  = ~m_req_q;
            state_d  = WAIT;
        end else if (state_q == WAIT && m_ack == m_req_q) begin
            for (int i = 0; i < NCH; i++)
                dout_d[i*16 +: 16] = (grant_q[i] && !m_we_q) ? m_dout : dout_q[i*16 +: 16];
            ack_d   = (ack_q & ~grant_q) | (ch_req & grant_q);
            last_d  = (PRIO0 && win_q == '0) ? last_q : win_q;
            grant_d = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= IW'(NCH - 1);
            win_q    <= '0;
            ack_q    <= '0;
            dout_q   <= '0;
            grant_q  <= '0;
            m_addr_q <= '0;
            m_din_q  <= '0;
            m_be_q   <= '0;
            m_we_q   <= 1'b0;
            m_req_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            ack_q    <= ack_d;
            dout_q   <= dout_d;
            grant_q  <= grant_d;
            m_addr_q <= m_addr_d;
            m_din_q  <= m_din_d;
            m_be_q   <= m_be_d;
            m_we_q   <= m_we_d;
            m_req_q  <= m_req_d;
        end
    end

    assign ch_ack  = ack_q;
    assign ch_dout = dout_q;
    assign grant   = grant_q;
    assign m_addr  = m_addr_q;
    assign m_din   = m_din_q;
    assign m_be    = m_be_q;
    assign m_we    = m_we_q;
    assign m_req   = m_req_q;
endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: scoreboard bench for ddram_arb with a toggle-handshake DDRAM model.
module tb_ddram_arb;
    localparam int NCH = 3;
    localparam int AW  = 27;
`ifdef DDRAM_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef struct {
        int          ch;
        logic [26:0] addr;
        logic [15:0] din;
        logic [1:0]  be;
        logic        we;
    } txn_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH*AW-1:0] ch_addr = '0;
    logic [NCH*16-1:0] ch_din = '0;
    logic [NCH*2-1:0]  ch_be = '0;
    logic [NCH-1:0]    ch_we = '0;
    logic [NCH-1:0]    ch_req = '0;
    logic [NCH-1:0]    ch_ack;
    logic [NCH*16-1:0] ch_dout;
    logic [NCH-1:0]    grant;
    logic [AW-1:0]     m_addr;
    logic [15:0]       m_din;
    logic [1:0]        m_be;
    logic              m_we, m_req;
    logic              m_ack;
    logic [15:0]       m_dout;

    int n_cmp = 0;
    int n_bad = 0;
    int lat = 5;
    int cnt;
    txn_t exp_q[$];
    logic [15:0] exp_dout [NCH];
    logic prev_mreq = 1'b0;
    logic [NCH-1:0] prev_ack = '0;
    int cur_ch = 0;

    ddram_arb #(.NCH(NCH), .AW(AW)) dut (
        .DDRAM_CLK (clk),
        .reset_n   (reset_n),
        .ch_addr   (ch_addr),
        .ch_din    (ch_din),
        .ch_be     (ch_be),
        .ch_we     (ch_we),
        .ch_req    (ch_req),
        .ch_ack    (ch_ack),
        .ch_dout   (ch_dout),
        .grant     (grant),
        .m_addr    (m_addr),
        .m_din     (m_din),
        .m_be      (m_be),
        .m_we      (m_we),
        .m_req     (m_req),
        .m_ack     (m_ack),
        .m_dout    (m_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_val(input logic [26:0] a);
        return a[15:0] ^ 16'hACDB;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Downstream model: answers lat edges after seeing a new request, shares reset_n.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_ack  <= 1'b0;
            m_dout <= 16'h0;
            cnt    <= 0;
        end else if (m_req != m_ack) begin
            if (cnt + 1 >= lat) begin
                m_ack  <= m_req;
                m_dout <= rd_val(m_addr);
                cnt    <= 0;
            end else begin
                cnt <= cnt + 1;
            end
        end
    end

    // Monitor: each new downstream request pops the scoreboard; each ack checks channel and data.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_mreq = m_req;
            prev_ack  = ch_ack;
        end else begin
            if (m_req != prev_mreq) begin
                if (exp_q.size() == 0) begin
                    chk("grant_unexpected", grant, 0);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    cur_ch = e.ch;
                    chk("grant", grant, 64'(1) << e.ch);
                    chk("m_addr", m_addr, e.addr);
                    chk("m_din", m_din, e.din);
                    chk("m_be", m_be, e.be);
                    chk("m_we", m_we, e.we);
                    if (!e.we) exp_dout[e.ch] = rd_val(e.addr);
                end
                prev_mreq = m_req;
            end
            for (int c = 0; c < NCH; c++) begin
                if (ch_ack[c] != prev_ack[c]) begin
                    chk("ack_ch", c, cur_ch);
                    chk("ch_dout", ch_dout[c*16 +: 16], exp_dout[c]);
                end
            end
            prev_ack = ch_ack;
        end
    end

    task automatic req(input int c, input logic [26:0] a, input logic [15:0] d,
                       input logic [1:0] b, input logic w, input bit front = 1'b0);
        txn_t e;
        ch_addr[c*AW +: AW] = a;
        ch_din[c*16 +: 16]  = d;
        ch_be[c*2 +: 2]     = b;
        ch_we[c]            = w;
        ch_req[c]           = !ch_req[c];
        e = '{c, a, d, b, w};
        if (front) exp_q.push_front(e);
        else exp_q.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        while (ch_ack != ch_req && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("done", ch_ack ^ ch_req, 0);
        @(negedge clk);
    endtask

    task automatic clear_model();
        ch_req = '0;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) exp_dout[c] = 16'h0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        logic m0, a0;
        int n, issued, guard;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", ch_ack, 0);
        chk("rst_dout", ch_dout, 0);
        chk("rst_grant", grant, 0);
        chk("rst_mreq", m_req, 0);
        chk("rst_maddr", m_addr, 0);
        chk("rst_mwe", m_we, 0);
        reset_n = 1'b1;
        // write on ch0 leaves its read data untouched
        @(posedge clk); #1;
        req(0, 27'h10, 16'hA55A, 2'b01, 1'b1);
        wait_done();
        chk("wr_dout0", ch_dout[15:0], 16'h0);
        chk("wr_ack0", ch_ack[0], 1);
        // contention right after reset, twice
        do_reset();
        for (int r = 0; r < 2; r++) begin
            @(posedge clk); #1;
            req(0, 27'h100 + 27'(r), 16'h1111, 2'b11, 1'b0);
            req(1, 27'h200 + 27'(r), 16'h2222, 2'b10, 1'b0);
            req(2, 27'h300 + 27'(r), 16'h3333, 2'b11, 1'b1);
            wait_done();
        end
        // single read on ch1 with latency checks
        @(posedge clk); #1;
        m0 = m_req;
        a0 = ch_ack[1];
        req(1, 27'h0001234, 16'h0, 2'b11, 1'b0);
        @(negedge clk);
        chk("rd_mreq_hold", m_req, m0);
        @(negedge clk);
        chk("rd_mreq_tog", m_req, !m0);
        chk("rd_maddr", m_addr, 27'h1234);
        n = 0;
        while (m_ack != m_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_ack_hold", ch_ack[1], a0);
        @(negedge clk);
        chk("rd_ack_tog", ch_ack[1], !a0);
        chk("rd_grant_idle", grant, 0);
        chk("rd_dout", ch_dout[31:16], 16'hBEEF);
        // ch0 and ch2 with last=1
        @(posedge clk); #1;
        if (PRIO0) begin
            req(0, 27'h50, 16'h0, 2'b11, 1'b0);
            req(2, 27'h52, 16'h0, 2'b11, 1'b0);
        end else begin
            req(2, 27'h52, 16'h0, 2'b11, 1'b0);
            req(0, 27'h50, 16'h0, 2'b11, 1'b0);
        end
        wait_done();
        // sustained ch0/ch1 contention for 20 transactions
        @(posedge clk); #1;
        if (PRIO0) begin
            req(0, 27'h400, 16'h0, 2'b11, 1'b0);
            req(1, 27'h401, 16'h0, 2'b11, 1'b0);
        end else begin
            req(1, 27'h401, 16'h0, 2'b11, 1'b0);
            req(0, 27'h400, 16'h0, 2'b11, 1'b0);
        end
        issued = 2;
        guard = 0;
        while (issued < 20 && guard < 2000) begin
            @(negedge clk);
            guard++;
            for (int c = 0; c < 2; c++) begin
                if (ch_ack[c] == ch_req[c] && issued < 20) begin
                    req(c, 27'h400 + 27'(issued), 16'h0, 2'b11, 1'b0, PRIO0 && c == 0);
                    issued++;
                end
            end
        end
        chk("starve_issued", issued, 20);
        wait_done();
        // zero-latency downstream, back-to-back reads on ch2
        lat = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req(2, 27'h2000 + 27'(k * 3), 16'h0, 2'b11, 1'b0);
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (ch_ack[2] != ch_req[2] && n < 20);
            chk("zl_cycles", n, 3);
        end
        @(negedge clk);
        // reset while waiting on the downstream ack
        lat = 5;
        @(posedge clk); #1;
        req(1, 27'h3333, 16'h0, 2'b11, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        clear_model();
        #1;
        chk("midrst_ack", ch_ack, 0);
        chk("midrst_mreq", m_req, 0);
        chk("midrst_grant", grant, 0);
        chk("midrst_dout", ch_dout, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        req(2, 27'h4444, 16'h0, 2'b11, 1'b0);
        wait_done();
        chk("post_rst_dout", ch_dout[47:32], rd_val(27'h4444));
        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ddram_arb.md
Name: ddram_arb

Overview:
- Toggle-handshake arbiter sharing the single 16-bit DDRAM client port (rom_req/rom_ack style: addr, din, be, we, dout) among NCH requesters.
- Typical requesters: CPU ROM fetch, cart save/backup RAM, MSU/PCM streamer.
- Sits in the DDRAM_CLK domain between requesters and the ddram controller.
- Latches one request at a time, forwards it downstream, and returns read data plus ack to the granted requester.

Parameters:
- NCH, 3, number of requester channels (2..8).
- AW, 27, word-address width (address bits [27:1]).

Ports:
- DDRAM_CLK  in  1  clock for all logic.
- reset_n  in  1  asynchronous active-low reset.
- ch_addr  in  NCH*AW  per-channel word address; channel i occupies bits [i*AW +: AW].
- ch_din  in  NCH*16  per-channel write data.
- ch_be  in  NCH*2  per-channel byte enables.
- ch_we  in  NCH  1 = write, 0 = read.
- ch_req  in  NCH  per-channel toggle request.
- ch_ack  out  NCH  per-channel toggle acknowledge.
- ch_dout  out  NCH*16  per-channel registered read data.
- grant  out  NCH  one-hot channel currently being serviced; 0 when idle.
- m_addr  out  AW  downstream address.
- m_din  out  16  downstream write data.
- m_be  out  2  downstream byte enables.
- m_we  out  1  downstream write flag.
- m_req  out  1  downstream toggle request.
- m_ack  in  1  downstream toggle acknowledge.
- m_dout  in  16  downstream read data; valid when m_ack==m_req.

Behaviour:
- Reset values: ch_ack=0, ch_dout=0, grant=0, m_addr/m_din/m_be/m_we=0, m_req=0, state=IDLE, last=NCH-1, so channel 0 wins the first arbitration.
- Pending definition: channel i is pending when ch_req[i] != ch_ack[i].
- States: IDLE and WAIT only.
- IDLE, any channel pending:
  - Pick a winner round-robin, searching from last+1 with wrap-around modulo NCH.
  - Latch that channel's addr/din/be/we into m_* and set grant one-hot.
  - Toggle m_req and go to WAIT; all of this on the same edge.
- WAIT, when m_ack==m_req:
  - If m_we=0, capture m_dout into ch_dout[winner]; writes leave ch_dout unchanged.
  - Set ch_ack[winner]=ch_req[winner], last=winner, grant=0, and return to IDLE.
- Latency:
  - m_req toggles 1 cycle after ch_req toggles, when idle and uncontested.
  - ch_ack toggles on the cycle after m_ack matches.
  - At least one IDLE cycle separates transactions.
- Requester obligations: hold addr/din/be/we stable from the ch_req toggle until ch_ack matches. ch_dout stays valid until the channel's next read completes.
- No request pending: stay in IDLE; m_* hold their last values and m_req is unchanged.
- m_ack changing while in IDLE: ignored.
- Channel re-toggling ch_req before its ack: this is a protocol violation. It is treated as "not pending" when equality is reached; no queueing.
- Simultaneous pending requests: exactly one is granted. Under sustained contention each channel is serviced within NCH transactions.
- ch_req toggling on the same edge as that channel's ack: the new toggle is seen in the next IDLE evaluation.
- Reset asserted mid-WAIT:
  - Everything returns to reset values immediately.
  - The downstream controller must share reset_n so m_ack also returns to 0; otherwise the handshake desyncs.
- Width rules: the round-robin index is $clog2(NCH) bits, and wrap-around is explicit, not power-of-two reliant.

Optional Feature:
- Macro: DDRAM_ARB_PRIO0_EN.
- Defined:
  - Channel 0 has absolute priority; whenever it is pending in IDLE it wins.
  - Round-robin applies only among channels 1..NCH-1, and last is updated only by those channels.
- Undefined: pure round-robin across all channels.

Decomposition:
- Package ddram_arb_pkg:
  - state enum (IDLE, WAIT).
  - Constants: default NCH=3 and AW=27.
  - Function clog2_min1 for the index width.
- Sub-module ddram_arb_rr:
  - Combinational round-robin picker with inputs pending[NCH] and last index.
  - Outputs: winner index and a valid flag.
  - Reused by both macro variants; with the macro, the picker receives the pending vector with bit 0 masked.

Test Plan:
- Single read: ch1 addr=0x0001234, toggle ch_req[1]; model answers with m_dout=0xBEEF after 5 cycles -> m_addr=0x0001234, m_we=0, m_req toggles 1 cycle later, ch_dout[1]=0xBEEF, ch_ack[1] toggles 1 cycle after m_ack, grant returns to 0.
- Write: ch0 addr=0x10, din=0xA55A, be=2'b01, we=1 -> m_din=0xA55A, m_be=01, m_we=1; ch_dout[0] stays 0; ch_ack[0] toggles.
- Contention: toggle all three ch_req on one cycle after reset -> service order 0,1,2. Re-toggle all -> order 0,1,2 again. Re-toggle only 0 and 2 with last=1 -> order 2,0.
- Starvation check: ch0 and ch1 re-request immediately after each ack for 20 transactions -> grants strictly alternate; no channel waits more than NCH transactions. With DDRAM_ARB_PRIO0_EN, ch0 always wins and ch1 proceeds only when ch0 is idle.
- Reset mid-WAIT: assert reset_n=0 while waiting on m_ack -> ch_ack=0, m_req=0, grant=0 immediately. After release, the first pending channel is serviced normally.
- Zero-latency downstream: the model mirrors m_ack=m_req on the next cycle for back-to-back reads on ch2 -> each transaction takes 3 cycles and data is correct for each address.
